// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: core-wide constants, FSM encoding and stage-control bundle shared by the pipeline controller and datapath
package pipeline_ctrl_pkg;
  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;
  typedef struct packed {
    logic pc_en;
    logic q1q2_en;
    logic q2q3_en;
    logic q3q4_en;
    logic q4q5_en;
    logic q1q2_flush;
    logic q2q3_flush;
    logic q4q5_bubble;
  } ctrl_t;
  localparam ctrl_t CTRL_INIT = 8'b00000_111;
  localparam ctrl_t CTRL_MEM_WAIT = 8'b00000_001;
  localparam ctrl_t CTRL_HALT = 8'b00000_000;
  localparam ctrl_t CTRL_BRANCH = 8'b11111_110;
  localparam ctrl_t CTRL_LOAD_USE = 8'b00111_010;
  localparam ctrl_t CTRL_NORMAL = 8'b11111_000;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and stage enable/flush/counter outputs; master = controller, slave = datapath
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
);
  reg_idx_t q2_rs1;
  reg_idx_t q2_rs2;
  logic q2_uses_rs1;
  logic q2_uses_rs2;
  reg_idx_t q3_rd;
  logic q3_mem_read;
  logic q3_branch_taken;
  logic q4_dmem_req;
  logic dmem_ready;
  logic pc_en;
  logic q1q2_en;
  logic q2q3_en;
  logic q3q4_en;
  logic q4q5_en;
  logic q1q2_flush;
  logic q2q3_flush;
  logic q4q5_bubble;
  logic dmem_timeout;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] flush_count;
  modport master (
    input q2_rs1, q2_rs2, q2_uses_rs1, q2_uses_rs2, q3_rd, q3_mem_read, q3_branch_taken,
    input q4_dmem_req, dmem_ready,
    output pc_en, q1q2_en, q2q3_en, q3q4_en, q4q5_en, q1q2_flush, q2q3_flush, q4q5_bubble,
    output dmem_timeout, stall_cycles, flush_count
  );
  modport slave (
    output q2_rs1, q2_rs2, q2_uses_rs1, q2_uses_rs2, q3_rd, q3_mem_read, q3_branch_taken,
    output q4_dmem_req, dmem_ready,
    input pc_en, q1q2_en, q2q3_en, q3q4_en, q4q5_en, q1q2_flush, q2q3_flush, q4q5_bubble,
    input dmem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: WIDTH-bit up counter that sticks at all-ones; ports clk, rst (async high), inc, count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage stall/flush sequencer (load-use bubble, branch flush, dmem freeze with timeout); ports clk, rst (async high), bus (master)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  pipeline_ctrl_if.master bus
);
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  logic [1:0] state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic timeout_q, timeout_nx;
  logic load_use, mem_wait_run;
  ctrl_t run_ctrl, ctrl;
  always_comb begin
    load_use = bus.q3_mem_read && bus.q3_rd != '0 &&
               ((bus.q2_uses_rs1 && bus.q2_rs1 == bus.q3_rd) ||
                (bus.q2_uses_rs2 && bus.q2_rs2 == bus.q3_rd));
    mem_wait_run = bus.q4_dmem_req && !bus.dmem_ready;
    run_ctrl = bus.q3_branch_taken ? CTRL_BRANCH : load_use ? CTRL_LOAD_USE : CTRL_NORMAL;
    ctrl = state == ST_INIT ? CTRL_INIT :
           state == ST_HALT ? CTRL_HALT :
           (state == ST_RUN ? !mem_wait_run : bus.dmem_ready) ? run_ctrl : CTRL_MEM_WAIT;
  end
  always_comb begin
    state_nx = state;
    wait_nx = wait_cnt;
    timeout_nx = timeout_q;
    if (state == ST_INIT) state_nx = ST_RUN;
    else if (state == ST_RUN && mem_wait_run) begin
      state_nx = ST_MEM_WAIT;
      wait_nx = WW'(1);
    end else if (state == ST_MEM_WAIT) begin
      if (bus.dmem_ready) begin
        state_nx = ST_RUN;
        wait_nx = '0;
      end else if (wait_cnt == WW'(WAIT_LIMIT)) begin
        state_nx = ST_HALT;
        timeout_nx = 1'b1;
      end else wait_nx = wait_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_INIT;
      wait_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
      timeout_q <= timeout_nx;
    end
  assign bus.pc_en = ctrl.pc_en;
  assign bus.q1q2_en = ctrl.q1q2_en;
  assign bus.q2q3_en = ctrl.q2q3_en;
  assign bus.q3q4_en = ctrl.q3q4_en;
  assign bus.q4q5_en = ctrl.q4q5_en;
  assign bus.q1q2_flush = ctrl.q1q2_flush;
  assign bus.q2q3_flush = ctrl.q2q3_flush;
  assign bus.q4q5_bubble = ctrl.q4q5_bubble;
  assign bus.dmem_timeout = timeout_q;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(!ctrl.pc_en),
    .count(bus.stall_cycles)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(ctrl == CTRL_BRANCH),
    .count(bus.flush_count)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl with WAIT_LIMIT=4, CNT_WIDTH=4
module tb_pipeline_ctrl;
  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_LU = 5'b00111;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_INIT = 3'b111;
  localparam logic [2:0] FL_BR = 3'b110;
  localparam logic [2:0] FL_LU = 3'b010;
  localparam logic [2:0] FL_MW = 3'b001;
  typedef struct {
    string tag;
    logic [4:0] en;
    logic [2:0] fl;
    logic to;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int es = 0;
  int ef = 0;
  always #5 clk = ~clk;
  pipeline_ctrl_if #(.CNT_WIDTH(4)) bus ();
  pipeline_ctrl #(.WAIT_LIMIT(4), .CNT_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s.%s got %0h expected %0h", tag, what, got, exp);
    end
  endtask
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic br, input logic req, input logic rdy);
    bus.q2_rs1 = rs1;
    bus.q2_rs2 = rs2;
    bus.q2_uses_rs1 = u1;
    bus.q2_uses_rs2 = u2;
    bus.q3_rd = rd;
    bus.q3_mem_read = mr;
    bus.q3_branch_taken = br;
    bus.q4_dmem_req = req;
    bus.dmem_ready = rdy;
  endtask
  task automatic cyc(input string tag, input logic [4:0] en, input logic [2:0] fl, input logic to);
    sb.push_back('{tag, en, fl, to});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      if (rst) begin
        es = 0;
        ef = 0;
      end
      chk(e.tag, "en", 32'({bus.pc_en, bus.q1q2_en, bus.q2q3_en, bus.q3q4_en, bus.q4q5_en}), 32'(e.en));
      chk(e.tag, "flush", 32'({bus.q1q2_flush, bus.q2q3_flush, bus.q4q5_bubble}), 32'(e.fl));
      chk(e.tag, "timeout", 32'(bus.dmem_timeout), 32'(e.to));
      chk(e.tag, "stall_cycles", 32'(bus.stall_cycles), 32'(es));
      chk(e.tag, "flush_count", 32'(bus.flush_count), 32'(ef));
      if (!rst) begin
        if (!e.en[4]) es = es == 15 ? 15 : es + 1;
        if (e.en[4] && e.fl[2]) ef = ef == 15 ? 15 : ef + 1;
      end
    end
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cyc("reset", EN_NONE, FL_INIT, 0);
    rst = 1'b0;
    cyc("init", EN_NONE, FL_INIT, 0);
    cyc("run0", EN_ALL, FL_NONE, 0);
    drive(5, 0, 1, 0, 5, 1, 0, 0, 0);
    cyc("lu_rs1", EN_LU, FL_LU, 0);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
    cyc("lu_x0", EN_ALL, FL_NONE, 0);
    drive(0, 7, 0, 1, 7, 1, 0, 0, 0);
    cyc("lu_rs2", EN_LU, FL_LU, 0);
    drive(0, 7, 0, 0, 7, 1, 0, 0, 0);
    cyc("lu_unused", EN_ALL, FL_NONE, 0);
    drive(5, 0, 1, 0, 5, 0, 0, 0, 0);
    cyc("no_load", EN_ALL, FL_NONE, 0);
    drive(5, 0, 1, 0, 5, 1, 1, 0, 0);
    cyc("br_lu", EN_ALL, FL_BR, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("post_br", EN_ALL, FL_NONE, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("req_rdy", EN_ALL, FL_NONE, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mw1", EN_NONE, FL_MW, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("mw2_br", EN_NONE, FL_MW, 0);
    cyc("mw3_br", EN_NONE, FL_MW, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    cyc("mw_exit_br", EN_ALL, FL_BR, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("post_mw", EN_ALL, FL_NONE, 0);
    drive(3, 0, 1, 0, 3, 1, 0, 1, 0);
    cyc("mw_over_lu", EN_NONE, FL_MW, 0);
    drive(3, 0, 1, 0, 3, 1, 0, 1, 1);
    cyc("mw_exit_lu", EN_LU, FL_LU, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("mw_limit", EN_NONE, FL_MW, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("mw_limit_exit", EN_ALL, FL_NONE, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc("mw_timeout", EN_NONE, FL_MW, 0);
    drive(5, 0, 1, 0, 5, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) cyc("halt", EN_NONE, FL_NONE, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("halt_idle", EN_NONE, FL_NONE, 1);
    rst = 1'b1;
    cyc("reset2", EN_NONE, FL_INIT, 0);
    rst = 1'b0;
    cyc("init2", EN_NONE, FL_INIT, 0);
    cyc("run2", EN_ALL, FL_NONE, 0);
    drive(9, 0, 1, 0, 9, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("sat_stall", EN_LU, FL_LU, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("sat_stall_hold", EN_ALL, FL_NONE, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc("sat_flush", EN_ALL, FL_BR, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("sat_flush_hold", EN_ALL, FL_NONE, 0);
    cyc("sat_flush_hold2", EN_ALL, FL_NONE, 0);
    @(negedge clk);
    chk("end", "sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
